kmeans_k2n2_ctrl: RTL and testbench
===================================

Name: kmeans_k2n2_ctrl

Overview:
- Iteration sequencer for the k=2, 2-dimension k-means datapath: input RAMs, the 4-stage distance pipeline and the accumulator block.
- Per iteration: clears the accumulators, streams every input address, aligns acc_enable to pipeline latency, reads per-centroid sums and counts, and divides them with an internal sequential divider.
- Updates the four centroid registers and repeats until the centroids stop changing or max_iter is reached.

Parameters:
- input_data_width, 8, centroid/data component width
- input_data_qty, 256, points per dataset
- input_data_qty_bit_width, 8, address and count width
- acc_width, 16, accumulator sum width
- pipe_latency, 4, cycles from address issue to valid pipeline output
- iter_width, 8, iteration counter width
- max_iter, 16, iteration limit (≥1)
- k0_d0_initial/k0_d1_initial/k1_d0_initial/k1_d1_initial, 0/0/1/1, centroid values loaded at reset and at start

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (rst=0 resets on posedge clk)
- start  in  1  begin clustering; sampled only in IDLE/DONE
- input_ram_rd_address  out  input_data_qty_bit_width  input RAM read address
- acc_rst  out  1  active-high clear to accumulator block
- acc_enable  out  1  accumulate current pipeline output
- rd_acc_en  out  1  accumulator read mode
- rd_acc_centroid  out  1  centroid being read
- acc0_output, acc1_output  in  acc_width  sums (combinational read)
- acc_counter_output  in  input_data_qty_bit_width  point count of rd_acc_centroid
- k0d0, k0d1, k1d0, k1d1  out  input_data_width each  current centroids (registered)
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high while in DONE
- iteration  out  iter_width  completed iterations

Behaviour:
- Reset: state IDLE; centroids = *_initial; address 0; acc_rst=1, all other control outputs 0; busy=0, done=0, iteration=0. Reset mid-operation aborts immediately with the same values; in-flight valid shift register cleared.
- States: IDLE → INIT → STREAM → DRAIN → READ → DIV → UPDATE → (INIT | DONE).
- IDLE/DONE: start=1 → INIT; centroids reloaded from *_initial, iteration=0, done drops. start in any other state is ignored.
- INIT (1 cycle): acc_rst=1, address 0.
- STREAM (input_data_qty cycles): address 0..qty-1, one per cycle. A valid bit enters a pipe_latency-deep shift register each cycle; acc_enable = shift register output, so acc_enable is high exactly in cycles t+pipe_latency for each address issued at t. The address counter wraps to 0 after qty-1; wrap is the exit condition.
- DRAIN (pipe_latency cycles): no new valid bits; exits when the shift register is empty. acc_enable and rd_acc_en are never high together.
- READ (2 cycles): rd_acc_en=1, rd_acc_centroid=0 then 1. Capture acc0/acc1/count per centroid into internal registers.
- DIV: four divisions in order k0d0, k0d1, k1d0, k1d1. Each is a restoring divider: 1 load cycle plus acc_width shift/subtract cycles, giving floor(sum/count). The new component is the quotient truncated to input_data_width. Count 0 → new value = old centroid component; the cycle count is unchanged.
- UPDATE (1 cycle): centroids ← new values; iteration += 1 (saturating).
  - All four new values equal the old → DONE.
  - Otherwise iteration == max_iter → DONE.
  - Otherwise → INIT.
- Iteration length: 1 + qty + pipe_latency + 2 + 4·(acc_width+1) + 1 cycles (80 for qty=4, latency 4, acc_width 16). busy is high for exactly that many cycles per iteration.
- Centroid outputs change only in UPDATE, at reset, or on start.

Test Plan:
- Reset: hold rst=0 for 3 cycles → busy=0, done=0, acc_rst=1, iteration=0, centroids 0/0/1/1; start while rst=0 is ignored.
- Timing, qty=4, pipe_latency=4: pulse start → acc_rst one cycle, addresses 0,1,2,3 on consecutive cycles, acc_enable high exactly 4 cycles starting 4 cycles after address 0, rd_acc_centroid 0 then 1.
- Convergence: 4 points (6,6), k0=(8,8), k1=(0,0) → after iteration 1 k0=(6,6), k1 stays (0,0) (count 0); iteration 2 unchanged → done=1, iteration=2, busy high 160 cycles.
- Floor and max_iter: points (6,6),(7,7),(6,6),(6,6), k0=(8,8), k1=(0,0), max_iter=1 → k0=(6,6) (25/4 floored), done=1, iteration=1.
- Immediate convergence: 4 points (5,5), k0=(5,5), k1=(200,200) → done after 80 cycles, iteration=1, centroids unchanged.
- Abort and restart: rst=0 during DIV → IDLE with initial centroids; a new start then completes identically to an uninterrupted run. A start pulse during STREAM causes no change.

Source files
------------

// File: rtl/kmeans_k2n2_ctrl.sv
// Iteration sequencer for the k=2, 2-D k-means datapath: streams the input RAM, aligns
// accumulation to the pipeline, divides the sums and updates the centroids until they settle.
module kmeans_k2n2_ctrl #(
  parameter int unsigned input_data_width         = 8,
  parameter int unsigned input_data_qty           = 256,
  parameter int unsigned input_data_qty_bit_width = 8,
  parameter int unsigned acc_width                = 16,
  parameter int unsigned pipe_latency             = 4,
  parameter int unsigned iter_width               = 8,
  parameter int unsigned max_iter                 = 16,
  parameter int unsigned k0_d0_initial            = 0,
  parameter int unsigned k0_d1_initial            = 0,
  parameter int unsigned k1_d0_initial            = 1,
  parameter int unsigned k1_d1_initial            = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic [input_data_qty_bit_width-1:0] input_ram_rd_address,
  output logic                                acc_rst,
  output logic                                acc_enable,
  output logic                                rd_acc_en,
  output logic                                rd_acc_centroid,
  input  logic [acc_width-1:0]                acc0_output,
  input  logic [acc_width-1:0]                acc1_output,
  input  logic [input_data_qty_bit_width-1:0] acc_counter_output,
  output logic [input_data_width-1:0]         k0d0,
  output logic [input_data_width-1:0]         k0d1,
  output logic [input_data_width-1:0]         k1d0,
  output logic [input_data_width-1:0]         k1d1,
  output logic                                busy,
  output logic                                done,
  output logic [iter_width-1:0]               iteration
);

  localparam int unsigned DW      = input_data_width;
  localparam int unsigned QW      = input_data_qty_bit_width;
  localparam int unsigned AW      = acc_width;
  localparam int unsigned DivCntW = $clog2(acc_width + 1);

  localparam logic [QW-1:0]         QtyLast  = QW'(input_data_qty - 1);
  localparam logic [DivCntW-1:0]    DivLast  = DivCntW'(acc_width);
  localparam logic [iter_width-1:0] MaxIterW = iter_width'(max_iter);
  localparam logic [DW-1:0]         InitC [4] = '{DW'(k0_d0_initial), DW'(k0_d1_initial),
                                                  DW'(k1_d0_initial), DW'(k1_d1_initial)};

  typedef enum logic [2:0] {
    StIdle, StInit, StStream, StDrain, StRead, StDiv, StUpdate, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [QW-1:0]           addr_q, addr_d;
  logic [pipe_latency-1:0] vsr_q, vsr_d;
  logic                    rd_sel_q, rd_sel_d;
  logic [AW-1:0]           sum_q [4];
  logic [AW-1:0]           sum_d [4];
  logic [QW-1:0]           cnt_q [2];
  logic [QW-1:0]           cnt_d [2];
  logic [1:0]              div_idx_q, div_idx_d;
  logic [DivCntW-1:0]      div_cnt_q, div_cnt_d;
  logic [AW:0]             rem_q, rem_d;
  logic [AW-1:0]           quo_q, quo_d;
  logic [QW-1:0]           dvs_q, dvs_d;
  logic [DW-1:0]           new_q [4];
  logic [DW-1:0]           new_d [4];
  logic [DW-1:0]           cent_q [4];
  logic [DW-1:0]           cent_d [4];
  logic [iter_width-1:0]   iter_q, iter_d;

  logic [AW:0] rem_sh, rem_sub;
  logic        rem_ge, changed;

  // Restoring divider step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_sh  = {rem_q[AW-1:0], quo_q[AW-1]};
    rem_sub = rem_sh - (AW+1)'(dvs_q);
    rem_ge  = rem_sh >= (AW+1)'(dvs_q);
  end

  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (new_q[i] != cent_q[i]) changed = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    vsr_d     = vsr_q << 1;
    rd_sel_d  = rd_sel_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    div_idx_d = div_idx_q;
    div_cnt_d = div_cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    new_d     = new_q;
    cent_d    = cent_q;
    iter_d    = iter_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cent_d  = InitC;
          iter_d  = '0;
          addr_d  = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        addr_d  = '0;
        state_d = StStream;
      end
      StStream: begin
        vsr_d[0] = 1'b1;
        if (addr_q == QtyLast) begin
          addr_d  = '0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: begin
        if (vsr_d == '0) begin
          rd_sel_d = 1'b0;
          state_d  = StRead;
        end
      end
      StRead: begin
        sum_d[{rd_sel_q, 1'b0}] = acc0_output;
        sum_d[{rd_sel_q, 1'b1}] = acc1_output;
        cnt_d[rd_sel_q]         = acc_counter_output;
        rd_sel_d                = ~rd_sel_q;
        if (rd_sel_q) begin
          div_idx_d = 2'd0;
          div_cnt_d = '0;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (div_cnt_q == '0) begin
          rem_d     = '0;
          quo_d     = sum_q[div_idx_q];
          dvs_d     = cnt_q[div_idx_q[1]];
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          rem_d = rem_ge ? rem_sub : rem_sh;
          quo_d = {quo_q[AW-2:0], rem_ge};
          if (div_cnt_q == DivLast) begin
            // An empty cluster keeps its old centroid component.
            new_d[div_idx_q] = (dvs_q == '0) ? cent_q[div_idx_q] : quo_d[DW-1:0];
            div_cnt_d        = '0;
            div_idx_d        = div_idx_q + 2'd1;
            if (div_idx_q == 2'd3) state_d = StUpdate;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end
      StUpdate: begin
        cent_d = new_q;
        iter_d = (iter_q == '1) ? iter_q : iter_q + 1'b1;
        if (!changed || iter_d == MaxIterW) state_d = StDone;
        else                                state_d = StInit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      vsr_q     <= '0;
      rd_sel_q  <= 1'b0;
      sum_q     <= '{default: '0};
      cnt_q     <= '{default: '0};
      div_idx_q <= '0;
      div_cnt_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      new_q     <= '{default: '0};
      cent_q    <= InitC;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      vsr_q     <= vsr_d;
      rd_sel_q  <= rd_sel_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      div_idx_q <= div_idx_d;
      div_cnt_q <= div_cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      new_q     <= new_d;
      cent_q    <= cent_d;
      iter_q    <= iter_d;
    end
  end

  assign input_ram_rd_address = addr_q;
  assign acc_rst              = (state_q == StIdle) || (state_q == StInit);
  assign acc_enable           = vsr_q[pipe_latency-1];
  assign rd_acc_en            = (state_q == StRead);
  assign rd_acc_centroid      = rd_sel_q;
  assign k0d0                 = cent_q[0];
  assign k0d1                 = cent_q[1];
  assign k1d0                 = cent_q[2];
  assign k1d1                 = cent_q[3];
  assign busy                 = (state_q != StIdle) && (state_q != StDone);
  assign done                 = (state_q == StDone);
  assign iteration            = iter_q;

endmodule

// File: tb/tb_kmeans_k2n2_ctrl.sv
// Bench for kmeans_k2n2_ctrl: four instances with different initial centroids, each with a
// behavioural accumulator block; final results come from a software k-means model.
module tb_kmeans_k2n2_ctrl;

  localparam int NI = 4;

  typedef struct {
    int inst;
    int c [4];
    int iter;
    int busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start     [NI];
  logic [7:0]  addr      [NI];
  logic        acc_rst_s [NI];
  logic        acc_en    [NI];
  logic        rd_en     [NI];
  logic        rd_c      [NI];
  logic [15:0] acc0      [NI];
  logic [15:0] acc1      [NI];
  logic [7:0]  acc_cnt   [NI];
  logic [7:0]  c00 [NI];
  logic [7:0]  c01 [NI];
  logic [7:0]  c10 [NI];
  logic [7:0]  c11 [NI];
  logic        busy [NI];
  logic        done [NI];
  logic [7:0]  iter [NI];
  int          pts  [NI][4][2];

  exp_t sb [$];
  int   aq [$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic nearest(input int x, input int y, input int a0, input int a1,
                                   input int b0, input int b1);
    int d0, d1;
    d0 = (x - a0) * (x - a0) + (y - a1) * (y - a1);
    d1 = (x - b0) * (x - b0) + (y - b1) * (y - b1);
    return d1 < d0;
  endfunction

  function automatic int init_c(input int g, input int j);
    case (g)
      0:       return (j < 2) ? 0 : 1;
      1, 2:    return (j < 2) ? 8 : 0;
      3:       return (j < 2) ? 5 : 200;
      default: return 0;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned K0 = (g == 1 || g == 2) ? 8 : (g == 3) ? 5 : 0;
    localparam int unsigned K1 = (g == 0) ? 1 : (g == 3) ? 200 : 0;
    localparam int unsigned MI = (g == 2) ? 1 : 16;

    logic [7:0]  hist [4];
    logic [15:0] s0 [2];
    logic [15:0] s1 [2];
    logic [7:0]  n  [2];
    logic [1:0]  p;
    logic        k;

    kmeans_k2n2_ctrl #(
      .input_data_width(8), .input_data_qty(4), .input_data_qty_bit_width(8),
      .acc_width(16), .pipe_latency(4), .iter_width(8), .max_iter(MI),
      .k0_d0_initial(K0), .k0_d1_initial(K0), .k1_d0_initial(K1), .k1_d1_initial(K1)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]),
      .input_ram_rd_address(addr[g]),
      .acc_rst(acc_rst_s[g]), .acc_enable(acc_en[g]),
      .rd_acc_en(rd_en[g]), .rd_acc_centroid(rd_c[g]),
      .acc0_output(acc0[g]), .acc1_output(acc1[g]), .acc_counter_output(acc_cnt[g]),
      .k0d0(c00[g]), .k0d1(c01[g]), .k1d0(c10[g]), .k1d1(c11[g]),
      .busy(busy[g]), .done(done[g]), .iteration(iter[g])
    );

    // Accumulator block: the point accumulated is the one addressed four cycles earlier.
    assign p = hist[3][1:0];
    assign k = nearest(pts[g][p][0], pts[g][p][1], c00[g], c01[g], c10[g], c11[g]);

    always @(posedge clk) begin
      hist[0] <= addr[g];
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      if (acc_rst_s[g]) begin
        s0 <= '{16'd0, 16'd0};
        s1 <= '{16'd0, 16'd0};
        n  <= '{8'd0, 8'd0};
      end else if (acc_en[g]) begin
        s0[k] <= s0[k] + 16'(pts[g][p][0]);
        s1[k] <= s1[k] + 16'(pts[g][p][1]);
        n[k]  <= n[k] + 8'd1;
      end
    end

    assign acc0[g]    = s0[rd_c[g]];
    assign acc1[g]    = s1[rd_c[g]];
    assign acc_cnt[g] = n[rd_c[g]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int g, output exp_t e);
    int c [4];
    int s [4];
    int nn [2];
    int nc, mi, kk;
    bit same;
    mi = (g == 2) ? 1 : 16;
    for (int j = 0; j < 4; j++) c[j] = init_c(g, j);
    e.iter = 0;
    for (int it = 0; it < mi; it++) begin
      for (int j = 0; j < 4; j++) s[j] = 0;
      nn[0] = 0;
      nn[1] = 0;
      for (int q = 0; q < 4; q++) begin
        kk = nearest(pts[g][q][0], pts[g][q][1], c[0], c[1], c[2], c[3]) ? 1 : 0;
        s[2*kk]   += pts[g][q][0];
        s[2*kk+1] += pts[g][q][1];
        nn[kk]++;
      end
      same = 1'b1;
      for (int j = 0; j < 4; j++) begin
        nc = (nn[j/2] == 0) ? c[j] : (s[j] / nn[j/2]) % 256;
        if (nc != c[j]) same = 1'b0;
        c[j] = nc;
      end
      e.iter++;
      if (same) break;
    end
    e.inst = g;
    e.c    = c;
    e.busy = e.iter * 80;
  endtask

  task automatic run(input int g, input bit timing, input int abort_k);
    exp_t e;
    int   k, nbusy, n_rst, n_en, n_rd, n_ovl, first_en, first_rd;
    int   rdc [2];
    model(g, e);
    if (abort_k < 0) sb.push_back(e);
    if (timing) for (int a = 0; a < 4; a++) aq.push_back(a);
    k = 0; nbusy = 0; n_rst = 0; n_en = 0; n_rd = 0; n_ovl = 0;
    first_en = -1; first_rd = -1; rdc[0] = -1; rdc[1] = -1;
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    forever begin
      if (busy[g]) nbusy++;
      if (timing && k < 80) begin
        if (k == 0) check("init_acc_rst", acc_rst_s[g], 1);
        if (acc_rst_s[g]) n_rst++;
        if (acc_en[g]) begin
          if (first_en < 0) first_en = k;
          n_en++;
        end
        if (rd_en[g]) begin
          if (first_rd < 0) first_rd = k;
          if (n_rd < 2) rdc[n_rd] = rd_c[g];
          n_rd++;
        end
        if (acc_en[g] && rd_en[g]) n_ovl++;
        if (k >= 1 && k <= 4 && aq.size() > 0) check("stream_addr", addr[g], aq.pop_front());
      end
      // A start pulse in STREAM must be ignored.
      start[g] = timing && (k == 2);
      if (k == abort_k) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", busy[g], 0);
        check("abort_done", done[g], 0);
        check("abort_acc_rst", acc_rst_s[g], 1);
        check("abort_acc_en", acc_en[g], 0);
        check("abort_iter", iter[g], 0);
        check("abort_k0d0", c00[g], init_c(g, 0));
        check("abort_k1d1", c11[g], init_c(g, 3));
        return;
      end
      if (done[g]) break;
      if (k > 3000) begin
        check("done_timeout", done[g], 1);
        break;
      end
      @(negedge clk);
      k++;
    end
    if (timing) begin
      check("acc_rst_cycles", n_rst, 1);
      check("acc_en_first", first_en, 5);
      check("acc_en_cycles", n_en, 4);
      check("rd_first", first_rd, 9);
      check("rd_cycles", n_rd, 2);
      check("rd_centroid0", rdc[0], 0);
      check("rd_centroid1", rdc[1], 1);
      check("en_rd_overlap", n_ovl, 0);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_inst", g, e.inst);
      check("k0d0", c00[g], e.c[0]);
      check("k0d1", c01[g], e.c[1]);
      check("k1d0", c10[g], e.c[2]);
      check("k1d1", c11[g], e.c[3]);
      check("iteration", iter[g], e.iter);
      check("busy_cycles", nbusy, e.busy);
      check("done", done[g], 1);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    pts[0] = '{'{0, 0}, '{2, 2}, '{10, 10}, '{12, 12}};
    pts[1] = '{'{6, 6}, '{6, 6}, '{6, 6}, '{6, 6}};
    pts[2] = '{'{6, 6}, '{7, 7}, '{6, 6}, '{6, 6}};
    pts[3] = '{'{5, 5}, '{5, 5}, '{5, 5}, '{5, 5}};

    // Reset held three cycles with a start pulse that must be ignored.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_acc_rst", acc_rst_s[0], 1);
    check("rst_acc_en", acc_en[0], 0);
    check("rst_rd_en", rd_en[0], 0);
    check("rst_addr", addr[0], 0);
    check("rst_iter", iter[0], 0);
    check("rst_k0d0", c00[0], 0);
    check("rst_k0d1", c01[0], 0);
    check("rst_k1d0", c10[0], 1);
    check("rst_k1d1", c11[0], 1);
    check("rst_k1d0_i3", c10[3], 200);
    rst = 1'b1;
    @(negedge clk);
    check("rst_start_ignored", busy[0], 0);

    run(0, 1'b1, -1);
    run(0, 1'b0, 20);
    run(0, 1'b0, -1);
    run(1, 1'b0, -1);
    run(2, 1'b0, -1);
    run(3, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
